cpu_core_mc: RTL and testbench

Parametrised multi-cycle successor to the 4-register 8-bit control unit. It fetches 8-bit instructions and executes them from a unified word memory over a req/ack handshake, with a configurable data width. It adds streaming OUT/IN ports, a run enable, HALT state, illegal-opcode flag and a debug register read port. It sits between the memory/arbiter and the I/O glue as the system's sole instruction processor.

---
 rtl/cpu_core_mc.sv | 253 +++++++++++++++++++++++++
 tb/tb_cpu_core_mc.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_core_mc.sv
// Multi-cycle core executing 8-bit instructions from a unified req/ack word memory,
// with streaming OUT/IN ports, run gating, HALT, illegal-opcode pulse and debug read port.
module cpu_core_mc #(
  parameter int              DATA_W   = 8,
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic              mem_req,
  output logic              mem_we,
  output logic [PC_W-1:0]   mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [PC_W-1:0]   pc,
  output logic              halted,
  output logic              retire,
  output logic              illegal,
  input  logic [1:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_OUT_W,
    S_IN_W,
    S_HALT
  } state_t;

  state_t              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [7:0]          instr_q, instr_d;
  logic [DATA_W-1:0]   regs_q [4];
  logic [DATA_W-1:0]   regs_d [4];
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [PC_W-1:0]     mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                in_ready_q, in_ready_d;
  logic                halted_q, halted_d;
  logic                retire_q, retire_d;
  logic                illegal_q, illegal_d;

  logic                is_sli;
  logic [3:0]          op;
  logic [1:0]          rd;
  logic [1:0]          rs;
  logic [3:0]          imm4;
  logic [DATA_W-1:0]   rd_val;
  logic [DATA_W-1:0]   rs_val;
  logic [PC_W-1:0]     pc_plus1;
  logic [PC_W-1:0]     pc_plus2;
  logic [PC_W-1:0]     next_pc;
  logic                done;

  assign is_sli   = (instr_q[7:6] == 2'b11);
  assign op       = instr_q[7:4];
  assign rd       = instr_q[3:2];
  assign rs       = instr_q[1:0];
  assign imm4     = {instr_q[5:4], instr_q[1:0]};
  assign rd_val   = regs_q[rd];
  assign rs_val   = regs_q[rs];
  assign pc_plus1 = pc_q + PC_W'(1);
  assign pc_plus2 = pc_q + PC_W'(2);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    regs_d      = regs_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    in_ready_d  = in_ready_q;
    halted_d    = halted_q;
    retire_d    = 1'b0;
    illegal_d   = 1'b0;
    done        = 1'b0;
    next_pc     = pc_plus1;

    case (state_q)
      S_FETCH: begin
        // Once raised, the request is held until ack regardless of run.
        if (mem_req_q) begin
          if (mem_ack) begin
            instr_d   = mem_rdata[7:0];
            mem_req_d = 1'b0;
            state_d   = S_EXEC;
          end
        end else if (run) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = pc_q;
        end
      end

      S_EXEC: begin
        done = 1'b1;
        if (is_sli) begin
          regs_d[rd] = {rd_val[DATA_W-5:0], imm4};
        end else begin
          case (op)
            4'b0000: begin
              if (rs == 2'd1) begin
                done     = 1'b0;
                state_d  = S_HALT;
                halted_d = 1'b1;
                retire_d = 1'b1;
              end
            end
            4'b0001: regs_d[rd] = rd_val - rs_val;
            4'b0110: regs_d[rd] = ~(rd_val & rs_val);
            4'b0111: regs_d[rd] = rd_val + rs_val;
            4'b0100: begin
              if ((rs == 2'd0 && rd_val == '0) || (rs == 2'd1 && rd_val != '0))
                next_pc = pc_plus2;
            end
            4'b0101: begin
              // Target comes from the pre-write register value, so Rd==Rs still jumps to the old value.
              regs_d[rd] = DATA_W'(pc_plus1);
              next_pc    = PC_W'(rs_val);
            end
            4'b1000: begin
              case (rs)
                2'd0: regs_d[rd] = rd_val + DATA_W'(1);
                2'd1: regs_d[rd] = rd_val - DATA_W'(1);
                2'd2: begin
                  done        = 1'b0;
                  state_d     = S_OUT_W;
                  out_valid_d = 1'b1;
                  out_data_d  = rd_val;
                end
                default: begin
                  done       = 1'b0;
                  state_d    = S_IN_W;
                  in_ready_d = 1'b1;
                end
              endcase
            end
            4'b0010, 4'b0011: begin
              done        = 1'b0;
              state_d     = S_MEM;
              mem_req_d   = 1'b1;
              mem_we_d    = (op == 4'b0011);
              mem_addr_d  = PC_W'(rs_val);
              mem_wdata_d = rd_val;
            end
            4'b1001, 4'b1010, 4'b1011: illegal_d = 1'b1;
            default: ;
          endcase
        end
      end

      S_MEM: begin
        if (mem_ack) begin
          if (!mem_we_q)
            regs_d[rd] = mem_rdata;
          done = 1'b1;
        end
      end

      S_OUT_W: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          done        = 1'b1;
        end
      end

      S_IN_W: begin
        if (in_valid) begin
          regs_d[rd] = in_data;
          in_ready_d = 1'b0;
          done       = 1'b1;
        end
      end

      default: ;
    endcase

    // Retiring an instruction launches the next fetch in the same edge when run allows it.
    if (done) begin
      pc_d       = next_pc;
      retire_d   = 1'b1;
      state_d    = S_FETCH;
      mem_req_d  = run;
      mem_we_d   = 1'b0;
      mem_addr_d = next_pc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      instr_q     <= '0;
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      in_ready_q  <= 1'b0;
      halted_q    <= 1'b0;
      retire_q    <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      regs_q      <= regs_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      in_ready_q  <= in_ready_d;
      halted_q    <= halted_d;
      retire_q    <= retire_d;
      illegal_q   <= illegal_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign in_ready  = in_ready_q;
  assign pc        = pc_q;
  assign halted    = halted_q;
  assign retire    = retire_q;
  assign illegal   = illegal_q;
  assign dbg_data  = regs_q[dbg_sel];

endmodule

// File: tb/tb_cpu_core_mc.sv
// Scoreboard bench for cpu_core_mc: word memory with programmable ack delay, OUT/IN stimulus,
// expected retire PCs, stores, OUT payloads and illegal pulses queued per program.
module tb_cpu_core_mc;
  localparam int DW = 8;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          run;
  logic          mem_req, mem_we, mem_ack;
  logic [PW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_data;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_data;
  logic [PW-1:0] pc;
  logic          halted, retire, illegal;
  logic [1:0]    dbg_sel;
  logic [DW-1:0] dbg_data;

  always #5 clk = ~clk;

  cpu_core_mc #(.DATA_W(DW), .PC_W(PW), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .run(run),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .pc(pc), .halted(halted), .retire(retire), .illegal(illegal),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  // Word memory: 256 entries, ack after ack_delay wait cycles.
  logic [7:0] mem [256];
  int ack_delay = 0;
  int wait_cnt  = 0;
  assign mem_ack   = mem_req && (wait_cnt >= ack_delay);
  assign mem_rdata = mem[mem_addr[7:0]];

  always @(posedge clk) begin
    if (!rst)                    wait_cnt <= 0;
    else if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
    else                         wait_cnt <= 0;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  int         exp_pc_q[$];
  logic [7:0] exp_out_q[$];
  logic [7:0] exp_wa_q[$];
  logic [7:0] exp_wd_q[$];
  int         exp_ill_q[$];

  logic          prev_req, prev_ack, prev_we, prev_ov, prev_or;
  logic [PW-1:0] prev_addr;
  logic [DW-1:0] prev_wdata, prev_od;

  // Monitor: samples on the falling edge, pops expectations on each DUT transaction.
  always @(negedge clk) begin
    if (!rst) begin
      prev_req = 1'b0; prev_ack = 1'b0; prev_ov = 1'b0; prev_or = 1'b0;
      prev_we = 1'b0; prev_addr = '0; prev_wdata = '0; prev_od = '0;
    end else begin
      if (retire) begin
        $display("retire  pc=%04h halted=%0b", pc, halted);
        check("retire_pending", exp_pc_q.size() > 0, 1);
        if (exp_pc_q.size() > 0) check("retire_pc", pc, exp_pc_q.pop_front());
      end
      if (illegal) begin
        $display("illegal pc=%04h", pc);
        check("illegal_pending", exp_ill_q.size() > 0, 1);
        if (exp_ill_q.size() > 0) check("illegal_pc", pc, exp_ill_q.pop_front());
      end
      if (mem_req && prev_req && !prev_ack) begin
        check("mem_addr_stable", mem_addr, prev_addr);
        check("mem_we_stable", mem_we, prev_we);
        if (mem_we) check("mem_wdata_stable", mem_wdata, prev_wdata);
      end
      if (mem_req && mem_ack) begin
        $display("mem     %s addr=%04h data=%02h", mem_we ? "wr" : "rd", mem_addr,
                 mem_we ? mem_wdata : mem_rdata);
        if (mem_we) begin
          check("store_pending", exp_wa_q.size() > 0, 1);
          if (exp_wa_q.size() > 0) begin
            check("store_addr", mem_addr, exp_wa_q.pop_front());
            check("store_data", mem_wdata, exp_wd_q.pop_front());
          end
          mem[mem_addr[7:0]] = mem_wdata;
        end
      end
      if (prev_ov && !prev_or) begin
        check("out_valid_held", out_valid, 1);
        check("out_data_stable", out_data, prev_od);
      end
      if (out_valid && out_ready) begin
        $display("out     data=%02h", out_data);
        check("out_pending", exp_out_q.size() > 0, 1);
        if (exp_out_q.size() > 0) check("out_data", out_data, exp_out_q.pop_front());
      end
      prev_req = mem_req; prev_ack = mem_ack; prev_we = mem_we;
      prev_addr = mem_addr; prev_wdata = mem_wdata;
      prev_ov = out_valid; prev_or = out_ready; prev_od = out_data;
    end
  end

  localparam logic [7:0] P1 [25] = '{
    8'hC3, 8'hD5, 8'h71, 8'h70, 8'hE6, 8'h34, 8'h28, 8'h8A, 8'h87, 8'h81,
    8'h40, 8'h41, 8'h90, 8'h90, 8'h10, 8'h40, 8'h01, 8'h41, 8'h6F, 8'h8C,
    8'h7D, 8'h1A, 8'hCA, 8'hC8, 8'h56
  };
  localparam int P1_PCS [26] = '{
    1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 13, 14, 15, 17, 18, 19, 20, 21, 22,
    23, 24, 'h20, 'h21, 'hA5, 'hA5
  };

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h01;
  endtask

  task automatic do_reset();
    run = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic check_reg(input int idx, input logic [7:0] exp);
    dbg_sel = 2'(idx);
    #1;
    check($sformatf("dbg_r%0d", idx), dbg_data, exp);
  endtask

  task automatic check_drained(input string name);
    check({name, "_pc_drained"}, exp_pc_q.size(), 0);
    check({name, "_out_drained"}, exp_out_q.size(), 0);
    check({name, "_store_drained"}, exp_wa_q.size(), 0);
    check({name, "_illegal_drained"}, exp_ill_q.size(), 0);
  endtask

  // Runs until HALT; OUT sink holds ready low 4 cycles, IN source waits 2 cycles.
  task automatic run_prog(input int max_cycles, input string name);
    int ow = 0;
    int iw = 0;
    bit seen_halt = 1'b0;
    run = 1'b1;
    for (int c = 0; c < max_cycles; c++) begin
      @(posedge clk); #1;
      if (halted) begin seen_halt = 1'b1; break; end
      out_ready = 1'b0; in_valid = 1'b0;
      if (out_valid) begin
        if (ow >= 4) begin out_ready = 1'b1; ow = 0; end else ow++;
      end
      if (in_ready) begin
        if (iw >= 2) begin in_valid = 1'b1; iw = 0; end else iw++;
      end
    end
    out_ready = 1'b0; in_valid = 1'b0;
    check({name, "_halted"}, seen_halt, 1);
    @(negedge clk); #1;
  endtask

  task automatic check_halt_quiet(input string name);
    int reqs = 0;
    repeat (10) begin @(negedge clk); if (mem_req) reqs++; end
    check({name, "_halt_no_req"}, reqs, 0);
    check({name, "_halt_held"}, halted, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst = 1'b0; run = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    in_data = 8'hA5; dbg_sel = 2'd0;
    clear_mem();
    repeat (2) @(negedge clk);
    check("rst_mem_req", mem_req, 0);
    check("rst_pc", pc, 16'h0000);
    check("rst_halted", halted, 0);
    check("rst_retire", retire, 0);
    check("rst_illegal", illegal, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);

    // Program A: ADD R0,R0 then HALT, zero-wait memory.
    clear_mem();
    mem[0] = 8'h70;
    ack_delay = 0;
    exp_pc_q.push_back(1); exp_pc_q.push_back(1);
    do_reset();
    run = 1'b1;
    k = 0;
    while (!mem_req && k < 10) begin @(negedge clk); k++; end
    check("a_first_req", mem_req, 1);
    check("a_first_addr", mem_addr, 16'h0000);
    check("a_first_we", mem_we, 0);
    run_prog(100, "a");
    check("a_pc", pc, 16'h0001);
    check_reg(0, 8'h00);
    check_halt_quiet("a");
    check_drained("a");

    // Program 1: SLI/ADD, STORE/LOAD, OUT/IN, skips, illegal, NAND/INC wrap, JALR; delayed acks.
    clear_mem();
    for (int i = 0; i < 25; i++) mem[i] = P1[i];
    mem[8'h20] = 8'h00;
    mem[8'h21] = 8'h5F;
    ack_delay = 3;
    for (int i = 0; i < 26; i++) exp_pc_q.push_back(P1_PCS[i]);
    exp_wa_q.push_back(8'h10); exp_wd_q.push_back(8'h5A);
    exp_out_q.push_back(8'h5A);
    exp_ill_q.push_back(14);
    do_reset();
    run_prog(2000, "p1");
    check("p1_pc", pc, 16'h00A5);
    check_reg(0, 8'h00);
    check_reg(1, 8'h19);
    check_reg(2, 8'h20);
    check_reg(3, 8'h22);
    check("p1_mem10", mem[8'h10], 8'h5A);
    check_halt_quiet("p1");
    check_drained("p1");

    // Program C: reset asserted while a LOAD is waiting for its ack.
    clear_mem();
    mem[0] = 8'hD0;
    mem[1] = 8'h28;
    ack_delay = 5;
    exp_pc_q.push_back(1);
    do_reset();
    run = 1'b1;
    k = 0;
    while (!(mem_req && mem_addr == 16'h0004) && k < 60) begin @(negedge clk); k++; end
    check("c_load_req_seen", mem_req && mem_addr == 16'h0004, 1);
    check_reg(0, 8'h04);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("c_rst_mem_req", mem_req, 0);
    check("c_rst_mem_we", mem_we, 0);
    check("c_rst_pc", pc, 16'h0000);
    check("c_rst_retire", retire, 0);
    check_reg(0, 8'h00);
    run = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    k = 0;
    repeat (6) begin @(negedge clk); if (mem_req) k++; end
    check("c_run0_no_req", k, 0);
    check_drained("c");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
